// File: rtl/osiris_pkg.sv
// Shared encodings for the load/store path: funct3 access sizes, LSU states
// and the legality/alignment helpers used when an access is offered.
package osiris_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_D  = 3'b011;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    localparam logic [2:0] LSU_WU = 3'b110;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_e;

    // Doubleword and unsigned-word accesses only exist on a 64-bit bus.
    function automatic logic lsu_legal(input logic [2:0] funct3, input logic dw64);
        case (funct3)
            LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU: return 1'b1;
            LSU_D, LSU_WU:                       return dw64;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return (addr_lo[0] == 1'b0);
            2'b10:   return (addr_lo[1:0] == 2'b00);
            default: return (addr_lo == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, lane-replicated store data and
// load extraction with sign/zero extension for one bus word.
module lsu_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
    input  logic [1:0]                      size_i,
    input  logic                            uns_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    output logic [DATA_WIDTH/8-1:0]         be_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [DATA_WIDTH-1:0]           rdata_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [3:0]            nbytes_s;
    logic [NB-1:0]         be_mask_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  sign_s;
    logic                  fill_s;

    // Size decode, enables, store replication and load extension.
    always_comb begin
        case (size_i)
            2'b00:   nbytes_s = 4'd1;
            2'b01:   nbytes_s = 4'd2;
            2'b10:   nbytes_s = 4'd4;
            default: nbytes_s = 4'd8;
        endcase

        be_mask_s = '0;
        wdata_o   = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes_s)) begin
                be_mask_s[i] = 1'b1;
            end else begin
                be_mask_s[i] = 1'b0;
            end
            // Sizes are powers of two, so the low bits of the lane pick the source byte.
            wdata_o[32'sd8*i +: 8] = wdata_i[32'sd8*(i & (int'(nbytes_s) - 32'sd1)) +: 8];
        end
        be_o = be_mask_s << offset_i;

        shifted_s = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            2'b00:   sign_s = shifted_s[7];
            2'b01:   sign_s = shifted_s[15];
            2'b10:   sign_s = shifted_s[31];
            default: sign_s = shifted_s[DATA_WIDTH-1];
        endcase
        fill_s = ~uns_i & sign_s;

        rdata_o = '0;
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (j < 32'sd8 * int'(nbytes_s)) begin
                rdata_o[j] = shifted_s[j];
            end else begin
                rdata_o[j] = fill_s;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between EX/MEM and a wait-stating data memory: req/gnt/rvalid
// handshake, misalignment trap, kill handling, bus timeout and pipeline stall.
module load_store_unit
    import osiris_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [2:0]              i_funct3,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_kill,
    output logic                    o_stall,
    output logic                    o_done,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_misaligned,
    output logic                    o_bus_err,
    output logic                    o_dmem_req,
    output logic                    o_dmem_we,
    output logic [ADDR_WIDTH-1:0]   o_dmem_addr,
    output logic [DATA_WIDTH/8-1:0] o_dmem_be,
    output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
    input  logic                    i_dmem_gnt,
    input  logic                    i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_dmem_rdata
);
    localparam int             NB       = DATA_WIDTH / 8;
    localparam int             OFFW     = $clog2(NB);
    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic           DW64     = (DATA_WIDTH == 64);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  kill_q, kill_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  err_q, err_d;

    logic                  op_s, ok_s, stall_s, req_s, granted_s;
    logic [NB-1:0]         be_s;
    logic [DATA_WIDTH-1:0] wrep_s, ext_s;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .offset_i (addr_q[OFFW-1:0]),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .wdata_i  (wdata_q),
        .rdata_i  (i_dmem_rdata),
        .be_o     (be_s),
        .wdata_o  (wrep_s),
        .rdata_o  (ext_s)
    );

    assign op_s      = i_valid & (i_mem_read | i_mem_write) & ~i_kill;
    assign ok_s      = lsu_legal(i_funct3, DW64) & lsu_aligned(i_addr[2:0], i_funct3[1:0]);
    assign granted_s = (state_q == LSU_RESP) | i_dmem_gnt;

    // Next-state, capture and pulse logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        stall_s = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                cnt_d  = '0;
                kill_d = 1'b0;
                if (op_s && ok_s) begin
                    stall_s = 1'b1;
                    state_d = LSU_REQ;
                    addr_d  = i_addr;
                    size_d  = i_funct3[1:0];
                    uns_d   = i_funct3[2];
                    we_d    = i_mem_write;
                    wdata_d = i_wdata;
                end else if (op_s) begin
                    mis_d = 1'b1;
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_REQ, LSU_RESP: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + CW'(1'b1);
                if ((state_q == LSU_REQ) && i_kill && !i_dmem_gnt) begin
                    state_d = LSU_IDLE;
                end else if (granted_s && i_dmem_rvalid) begin
                    // A killed access still has to drain its response before retiring silently.
                    if (kill_q || i_kill) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d = LSU_DONE;
                        rdata_d = we_q ? '0 : ext_s;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LSU_IDLE;
                    err_d   = 1'b1;
                end else if (granted_s) begin
                    state_d = LSU_RESP;
                    kill_d  = kill_q | i_kill;
                end else begin
                    state_d = state_q;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign req_s        = (state_q == LSU_REQ);
    assign o_stall      = stall_s;
    assign o_done       = (state_q == LSU_DONE);
    assign o_rdata      = rdata_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = err_q;
    assign o_dmem_req   = req_s;
    assign o_dmem_we    = req_s & we_q;
    assign o_dmem_addr  = req_s ? {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;
    assign o_dmem_be    = req_s ? be_s : '0;
    assign o_dmem_wdata = req_s ? wrep_s : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit and a 64-bit instance share
// control stimulus; each scenario task checks its own hand-computed results.
module tb_load_store_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, mem_read, mem_write, kill, gnt, rvalid;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata32, rdata32;
    logic [63:0] wdata64, rdata64;

    logic        s32, d32, mis32, err32, req32, we32;
    logic [31:0] rd32, addr32o, wd32;
    logic [3:0]  be32;
    logic        s64, d64, mis64, err64, req64, we64;
    logic [63:0] rd64, wd64;
    logic [31:0] addr64o;
    logic [7:0]  be64;

    int checks = 0;
    int failures = 0;
    int ndone;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut32 (
        .clk(clk), .rst(rst), .i_valid(valid), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata32), .i_kill(kill),
        .o_stall(s32), .o_done(d32), .o_rdata(rd32), .o_misaligned(mis32), .o_bus_err(err32),
        .o_dmem_req(req32), .o_dmem_we(we32), .o_dmem_addr(addr32o), .o_dmem_be(be32),
        .o_dmem_wdata(wd32), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata32)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut64 (
        .clk(clk), .rst(rst), .i_valid(valid), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata64), .i_kill(kill),
        .o_stall(s64), .o_done(d64), .o_rdata(rd64), .o_misaligned(mis64), .o_bus_err(err64),
        .o_dmem_req(req64), .o_dmem_we(we64), .o_dmem_addr(addr64o), .o_dmem_be(be64),
        .o_dmem_wdata(wd64), .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata64)
    );

    task automatic idle_in();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; kill = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; funct3 = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle_in(); addr = 32'h0;
        wdata32 = 32'h0; rdata32 = 32'h0; wdata64 = 64'h0; rdata64 = 64'h0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({s32, d32, mis32, err32, req32, we32} !== 6'b0) begin failures++; $display("FAIL reset_ctrl32 got=%b exp=000000", {s32, d32, mis32, err32, req32, we32}); end
        checks++; if ({rd32, addr32o, be32, wd32} !== 100'h0) begin failures++; $display("FAIL reset_data32 got=%h exp=0", {rd32, addr32o, be32, wd32}); end
        checks++; if ({s64, d64, mis64, err64, req64, we64, rd64, be64} !== 78'h0) begin failures++; $display("FAIL reset_all64 got=%h exp=0", {s64, d64, mis64, err64, req64, we64, rd64, be64}); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_lb_zero_wait();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b000; addr = 32'h103; #1;
        checks++; if ({s32, req32} !== 2'b10) begin failures++; $display("FAIL lb_c0_stall_req got=%b exp=10", {s32, req32}); end
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1; rdata32 = 32'h80FF_1234; #1;
        checks++; if ({s32, req32, we32, be32} !== 7'b1101000) begin failures++; $display("FAIL lb_c1_req got=%b exp=1101000", {s32, req32, we32, be32}); end
        checks++; if (addr32o !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=00000100", addr32o); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({d32, s32, req32} !== 3'b100) begin failures++; $display("FAIL lb_c2_done got=%b exp=100", {d32, s32, req32}); end
        checks++; if (rd32 !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", rd32); end
        @(negedge clk); #1;
        checks++; if ({d32, rd32} !== {1'b0, 32'hFFFF_FF80}) begin failures++; $display("FAIL lb_hold got=%b/%h exp=0/ffffff80", d32, rd32); end
    endtask

    task automatic test_sh_wait_states();
        @(negedge clk); valid = 1'b1; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata32 = 32'h1234_ABCD; #1;
        checks++; if (s32 !== 1'b1) begin failures++; $display("FAIL sh_c0_stall got=%b exp=1", s32); end
        ndone = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk); idle_in(); gnt = (c == 4); rvalid = (c == 6); #1;
            if (c <= 4) begin
                checks++; if ({req32, we32, addr32o, be32, wd32} !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD}) begin failures++; $display("FAIL sh_req_c%0d got=%b/%b/%h/%b/%h exp=1/1/00000200/1100/abcdabcd", c, req32, we32, addr32o, be32, wd32); end
            end else if (c <= 6) begin
                checks++; if ({req32, s32} !== 2'b01) begin failures++; $display("FAIL sh_resp_c%0d got=%b exp=01", c, {req32, s32}); end
            end else if (c == 7) begin
                checks++; if ({d32, s32, rd32} !== {2'b10, 32'h0}) begin failures++; $display("FAIL sh_done got=%b/%b/%h exp=1/0/00000000", d32, s32, rd32); end
            end else begin
                checks++; if ({d32, s32} !== 2'b00) begin failures++; $display("FAIL sh_after got=%b exp=00", {d32, s32}); end
            end
            if (c <= 4 && s32 !== 1'b1) begin checks++; failures++; $display("FAIL sh_stall_c%0d got=0 exp=1", c); end
            if (d32 === 1'b1) ndone++;
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL sh_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_misaligned();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101; #1;
        checks++; if ({s32, req32} !== 2'b00) begin failures++; $display("FAIL mis_c0 got=%b exp=00", {s32, req32}); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({mis32, req32, s32} !== 3'b100) begin failures++; $display("FAIL mis_pulse got=%b exp=100", {mis32, req32, s32}); end
        @(negedge clk); #1;
        checks++; if ({mis32, req32} !== 2'b00) begin failures++; $display("FAIL mis_clear got=%b exp=00", {mis32, req32}); end
    endtask

    task automatic test_lhu();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b101; addr = 32'h102;
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1; rdata32 = 32'h8001_0000; #1;
        checks++; if (be32 !== 4'b1100) begin failures++; $display("FAIL lhu_be got=%b exp=1100", be32); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({d32, rd32} !== {1'b1, 32'h0000_8001}) begin failures++; $display("FAIL lhu_rdata got=%b/%h exp=1/00008001", d32, rd32); end
    endtask

    task automatic test_kill_req();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk); idle_in(); kill = 1'b1; #1;
        checks++; if (req32 !== 1'b1) begin failures++; $display("FAIL killreq_req got=%b exp=1", req32); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({req32, s32, d32} !== 3'b000) begin failures++; $display("FAIL killreq_idle got=%b exp=000", {req32, s32, d32}); end
        @(negedge clk); #1;
        checks++; if (d32 !== 1'b0) begin failures++; $display("FAIL killreq_nodone got=%b exp=0", d32); end
    endtask

    task automatic test_kill_resp();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h304;
        @(negedge clk); idle_in(); gnt = 1'b1;
        @(negedge clk); idle_in(); kill = 1'b1; #1;
        checks++; if ({s32, req32} !== 2'b10) begin failures++; $display("FAIL killresp_resp got=%b exp=10", {s32, req32}); end
        @(negedge clk); idle_in(); rvalid = 1'b1; rdata32 = 32'hDEAD_BEEF;
        @(negedge clk); idle_in(); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h308; #1;
        checks++; if ({d32, rd32} !== {1'b0, 32'h0000_8001}) begin failures++; $display("FAIL killresp_nodone got=%b/%h exp=0/00008001", d32, rd32); end
        checks++; if (s32 !== 1'b1) begin failures++; $display("FAIL killresp_accept got=%b exp=1", s32); end
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1; rdata32 = 32'h1234_5678;
        @(negedge clk); idle_in(); #1;
        checks++; if ({d32, rd32} !== {1'b1, 32'h1234_5678}) begin failures++; $display("FAIL killresp_next got=%b/%h exp=1/12345678", d32, rd32); end
    endtask

    task automatic test_timeout();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); idle_in(); #1;
            if (c <= 8) begin
                checks++; if ({req32, s32, err32} !== 3'b110) begin failures++; $display("FAIL tmo_wait_c%0d got=%b exp=110", c, {req32, s32, err32}); end
            end else if (c == 9) begin
                checks++; if ({err32, req32, s32, d32} !== 4'b1000) begin failures++; $display("FAIL tmo_err got=%b exp=1000", {err32, req32, s32, d32}); end
            end else begin
                checks++; if (err32 !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", err32); end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(negedge clk); idle_in(); gnt = 1'b1;
        @(negedge clk); idle_in(); rst = 1'b0;
        @(negedge clk); rst = 1'b1; rvalid = 1'b1; rdata32 = 32'hCAFE_F00D; #1;
        checks++; if ({s32, d32, mis32, err32, req32, we32, rd32} !== 38'h0) begin failures++; $display("FAIL rstmid_outputs got=%b/%h exp=0", {s32, d32, mis32, err32, req32, we32}, rd32); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({d32, s32, req32, rd32} !== 35'h0) begin failures++; $display("FAIL rstmid_late_rvalid got=%b/%h exp=0", {d32, s32, req32}, rd32); end
    endtask

    task automatic test_dw64();
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b110; addr = 32'h14; #1;
        checks++; if (s64 !== 1'b1) begin failures++; $display("FAIL lwu64_stall got=%b exp=1", s64); end
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1; rdata64 = 64'h8000_0001_1234_5678; #1;
        checks++; if ({be64, addr64o} !== {8'hF0, 32'h10}) begin failures++; $display("FAIL lwu64_req got=%h/%h exp=f0/00000010", be64, addr64o); end
        checks++; if (mis32 !== 1'b1) begin failures++; $display("FAIL wu_on32_illegal got=%b exp=1", mis32); end
        @(negedge clk); idle_in(); #1;
        checks++; if ({d64, rd64} !== {1'b1, 64'h0000_0000_8000_0001}) begin failures++; $display("FAIL lwu64_rdata got=%b/%h exp=1/0000000080000001", d64, rd64); end
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h14;
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1;
        @(negedge clk); idle_in(); #1;
        checks++; if ({d64, rd64} !== {1'b1, 64'hFFFF_FFFF_8000_0001}) begin failures++; $display("FAIL lw64_rdata got=%b/%h exp=1/ffffffff80000001", d64, rd64); end
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; funct3 = 3'b011; addr = 32'h10;
        @(negedge clk); idle_in(); gnt = 1'b1; rvalid = 1'b1; #1;
        checks++; if ({be64, mis32} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL ld64_be got=%h/%b exp=ff/1", be64, mis32); end
        @(negedge clk); idle_in(); #1;
        checks++; if (rd64 !== 64'h8000_0001_1234_5678) begin failures++; $display("FAIL ld64_rdata got=%h exp=8000000112345678", rd64); end
        @(negedge clk); valid = 1'b1; mem_write = 1'b1; funct3 = 3'b000; addr = 32'h15; wdata64 = 64'h0123_4567_89AB_CDA5;
        @(negedge clk); idle_in(); #1;
        checks++; if ({we64, be64, wd64} !== {1'b1, 8'h20, 64'hA5A5_A5A5_A5A5_A5A5}) begin failures++; $display("FAIL sb64_req got=%b/%h/%h exp=1/20/a5a5a5a5a5a5a5a5", we64, be64, wd64); end
        @(negedge clk); gnt = 1'b1; rvalid = 1'b1;
        @(negedge clk); idle_in(); #1;
        checks++; if ({d64, rd64} !== {1'b1, 64'h0}) begin failures++; $display("FAIL sb64_done got=%b/%h exp=1/0", d64, rd64); end
    endtask

    initial begin
        test_reset();
        test_lb_zero_wait();
        test_sh_wait_states();
        test_misaligned();
        test_lhu();
        test_kill_req();
        test_kill_resp();
        test_timeout();
        test_reset_mid();
        test_dw64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
